data_bus_arbiter: RTL and testbench

Two-master arbiter for the single data port of `miriscv_ram`. It sits between the core's load/store interface (master 0) and a second bus master, such as the program loader or a DMA engine (master 1). Each cycle it grants at most one request and forwards it to the RAM data port, then routes the RAM read data back to the owner one cycle later. Master 0 has fixed priority, with two exceptions: a starvation counter guarantees master 1 forward progress, and master 1 may lock the bus for short bursts.

---
 rtl/data_bus_arbiter_pkg.sv | 18 +
 rtl/data_bus_arbiter_resp_tracker.sv | 45 ++++
 rtl/data_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_data_bus_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types for the two-master RAM data-port arbiter.
package arb_pkg;

  localparam int ARB_CNT_W = 4;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  typedef logic [ARB_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/data_bus_arbiter_resp_tracker.sv
// Remembers who owns the in-flight RAM access and steers the returning
// read data and rvalid pulse to that master one cycle after acceptance.
module arb_resp_tracker
  import arb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_gnt,
  input  logic        i_m1_gnt,
  input  logic        i_we,
  input  logic [31:0] i_rdata,
  output logic        o_m0_rvalid,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic [31:0] o_m1_rdata
);

  logic   r_resp_vld;
  owner_t r_resp_own;
  logic   r_resp_we;
  logic   w_live;

  // Capture each accepted transfer; a reset drops whatever is pending.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_resp_vld <= 1'b0;
      r_resp_own <= OWN_M0;
      r_resp_we  <= 1'b0;
    end else begin
      r_resp_vld <= i_m0_gnt | i_m1_gnt;
      r_resp_own <= i_m1_gnt ? OWN_M1 : OWN_M0;
      r_resp_we  <= i_we;
    end
  end

  // Responses are suppressed while reset is held; write responses carry no data.
  always_comb begin
    w_live      = r_resp_vld & ~i_rst;
    o_m0_rvalid = w_live & (r_resp_own == OWN_M0);
    o_m1_rvalid = w_live & (r_resp_own == OWN_M1);
    o_m0_rdata  = (o_m0_rvalid & ~r_resp_we) ? i_rdata : 32'd0;
    o_m1_rdata  = (o_m1_rvalid & ~r_resp_we) ? i_rdata : 32'd0;
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the RAM data port: master 0 has priority, master 1
// is protected by a starvation counter and may lock the bus for short bursts.
module data_bus_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_lock_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  output logic        m0_rvalid_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic [31:0] s_rdata_i
);

  localparam cnt_t C_MAX_WAIT = cnt_t'(MAX_WAIT);
  localparam cnt_t C_MAX_LOCK = cnt_t'(MAX_LOCK);

  arb_state_t r_state, w_state_nxt;
  cnt_t       r_wait_cnt, w_wait_nxt;
  cnt_t       r_lock_cnt, w_lock_nxt;
  logic       w_m0_gnt, w_m1_gnt;

  // Grant selection: master 0 wins in ARB unless master 1 has waited its limit.
  always_comb begin
    w_m0_gnt = 1'b0;
    w_m1_gnt = 1'b0;
    if (rst_i) begin
      w_m0_gnt = 1'b0;
      w_m1_gnt = 1'b0;
    end else begin
      case (r_state)
        ARB: begin
          w_m0_gnt = m0_req_i & ~(m1_req_i & (r_wait_cnt >= C_MAX_WAIT));
          w_m1_gnt = m1_req_i & ~w_m0_gnt;
        end
        LOCKED: begin
          w_m0_gnt = 1'b0;
          w_m1_gnt = m1_req_i;
        end
        default: begin
          w_m0_gnt = 1'b0;
          w_m1_gnt = 1'b0;
        end
      endcase
    end
  end

  // RAM port mux of the granted master's fields; all zero when idle.
  always_comb begin
    s_req_o   = w_m0_gnt | w_m1_gnt;
    s_we_o    = 1'b0;
    s_be_o    = 4'd0;
    s_addr_o  = 32'd0;
    s_wdata_o = 32'd0;
    if (w_m1_gnt) begin
      s_we_o    = m1_we_i;
      s_be_o    = m1_be_i;
      s_addr_o  = m1_addr_i;
      s_wdata_o = m1_wdata_i;
    end else if (w_m0_gnt) begin
      s_we_o    = m0_we_i;
      s_be_o    = m0_be_i;
      s_addr_o  = m0_addr_i;
      s_wdata_o = m0_wdata_i;
    end else begin
      s_we_o    = 1'b0;
    end
  end

  // Next-state, starvation and burst counters.
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_cnt;
    if (w_m1_gnt || !m1_req_i) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt < C_MAX_WAIT) begin
      w_wait_nxt = r_wait_cnt + 4'd1;
    end else begin
      w_wait_nxt = r_wait_cnt;
    end
    case (r_state)
      ARB: begin
        // A one-grant lock limit means the entering grant already ends the burst.
        if (w_m1_gnt && m1_lock_i && (C_MAX_LOCK > 4'd1)) begin
          w_state_nxt = LOCKED;
          w_lock_nxt  = 4'd1;
        end else begin
          w_state_nxt = ARB;
          w_lock_nxt  = '0;
        end
      end
      LOCKED: begin
        if (!m1_lock_i || !m1_req_i ||
            (w_m1_gnt && ((r_lock_cnt + 4'd1) >= C_MAX_LOCK))) begin
          w_state_nxt = ARB;
          w_lock_nxt  = '0;
        end else begin
          w_state_nxt = LOCKED;
          w_lock_nxt  = r_lock_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ARB;
        w_lock_nxt  = '0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ARB;
      r_wait_cnt <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_lock_cnt <= w_lock_nxt;
    end
  end

  assign m0_gnt_o = w_m0_gnt;
  assign m1_gnt_o = w_m1_gnt;

  arb_resp_tracker u_resp (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_m0_gnt    (w_m0_gnt),
    .i_m1_gnt    (w_m1_gnt),
    .i_we        (s_we_o),
    .i_rdata     (s_rdata_i),
    .o_m0_rvalid (m0_rvalid_o),
    .o_m1_rvalid (m1_rvalid_o),
    .o_m0_rdata  (m0_rdata_o),
    .o_m1_rdata  (m1_rdata_o)
  );

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: directed scenarios, then random traffic
// checked against a behavioural model of the arbitration rules and the RAM.
module tb_data_bus_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int MAX_LOCK = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata, s_rdata;

  always #5 clk = ~clk;

  data_bus_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_lock_i(m1_lock),
    .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt),
    .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
    .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_rdata_i(s_rdata)
  );

  // RAM slave: 16 words, read data one cycle after the request.
  logic [31:0] ram [16];
  logic [31:0] ram_rdata = 32'd0;
  assign s_rdata = ram_rdata;
  always @(posedge clk) begin
    if (s_req) begin
      if (s_we) begin
        for (int b = 0; b < 4; b++)
          if (s_be[b]) ram[s_addr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram[s_addr[5:2]];
      end
    end
  end

  // Reference model state.
  typedef struct {
    int          due;
    bit          own;
    logic [31:0] data;
  } exp_t;
  exp_t        q[$];
  logic [31:0] ref_mem [16];
  bit          locked;
  int          refused, burst;
  int          n_cmp = 0, n_err = 0, cyc = 0;
  int          m1_run, m1_run_max, m1_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_be = 4'd0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'd0; m1_addr = 32'd0; m1_wdata = 32'd0;
    m1_lock = 1'b0;
  endtask

  // Check one cycle's grants and RAM port, record the expected response, advance.
  task automatic cycle();
    bit          e0, e1, ewe;
    logic [3:0]  eb;
    logic [31:0] ea, ew;
    exp_t        t;
    #2;
    e0 = 1'b0; e1 = 1'b0;
    if (rst) begin
      locked = 1'b0; refused = 0; burst = 0;
      q.delete();
    end else if (locked) begin
      e1 = m1_req;
    end else begin
      e1 = m1_req && (!m0_req || refused >= MAX_WAIT);
      e0 = m0_req && !e1;
    end
    ewe = 1'b0; eb = 4'd0; ea = 32'd0; ew = 32'd0;
    if (e1) begin ewe = m1_we; eb = m1_be; ea = m1_addr; ew = m1_wdata; end
    if (e0) begin ewe = m0_we; eb = m0_be; ea = m0_addr; ew = m0_wdata; end
    chk("m0_gnt", 32'(m0_gnt), 32'(e0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e1));
    chk("s_req", 32'(s_req), 32'(e0 | e1));
    chk("s_we", 32'(s_we), 32'(ewe));
    chk("s_be", 32'(s_be), 32'(eb));
    chk("s_addr", s_addr, ea);
    chk("s_wdata", s_wdata, ew);
    if (e0 || e1) begin
      t.due  = cyc + 1;
      t.own  = e1;
      t.data = ewe ? 32'd0 : ref_mem[ea[5:2]];
      q.push_back(t);
      if (ewe)
        for (int b = 0; b < 4; b++)
          if (eb[b]) ref_mem[ea[5:2]][8*b +: 8] = ew[8*b +: 8];
    end
    if (!rst) begin
      refused = (m1_req && !e1) ? ((refused < MAX_WAIT) ? refused + 1 : refused) : 0;
      if (locked) begin
        if (e1) burst++;
        if (!m1_lock || !m1_req || burst >= MAX_LOCK) begin locked = 1'b0; burst = 0; end
      end else if (e1 && m1_lock && MAX_LOCK > 1) begin
        locked = 1'b1; burst = 1;
      end
    end
    m1_run = m1_gnt ? m1_run + 1 : 0;
    if (m1_run > m1_run_max) m1_run_max = m1_run;
    if (m1_gnt) m1_cnt++;
    @(negedge clk);
    cyc++;
  endtask

  // Monitor: every cycle either the due response appears on its owner, or nothing does.
  exp_t mt;
  always @(negedge clk) begin
    #4;
    if (q.size() > 0 && q[0].due == cyc) begin
      mt = q.pop_front();
      chk("m0_rvalid", 32'(m0_rvalid), 32'(!mt.own));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(mt.own));
      chk("m0_rdata", m0_rdata, mt.own ? 32'd0 : mt.data);
      chk("m1_rdata", m1_rdata, mt.own ? mt.data : 32'd0);
    end else begin
      chk("idle_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      chk("idle_rdata", m0_rdata | m1_rdata, 32'd0);
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    locked = 1'b0; refused = 0; burst = 0; m1_run = 0; m1_run_max = 0; m1_cnt = 0;

    // Reset with requests pending: nothing may be granted.
    idle(); rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
    cycle(); cycle();
    rst = 1'b0; idle();

    // Single master read of 0x10.
    m0_req = 1'b1; m0_addr = 32'h10; m0_be = 4'hF;
    cycle(); idle(); cycle();

    // Contention: two forced master-1 wins in ten cycles.
    m1_cnt = 0;
    m0_req = 1'b1; m0_addr = 32'h4; m1_req = 1'b1; m1_addr = 32'h8;
    for (int i = 0; i < 10; i++) cycle();
    chk("contention_m1_grants", 32'(m1_cnt), 32'd2);
    idle(); cycle();

    // Lock burst while master 0 keeps requesting.
    m1_run_max = 0;
    m0_req = 1'b1; m0_addr = 32'hC; m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h18;
    for (int i = 0; i < 14; i++) cycle();
    chk("lock_burst_len", 32'(m1_run_max), 32'(MAX_LOCK));
    idle(); cycle();

    // Early unlock after three locked grants; master 0 then wins.
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h1C;
    for (int i = 0; i < 3; i++) cycle();
    m1_lock = 1'b0; m0_req = 1'b1; m0_addr = 32'h24;
    cycle(); cycle();
    idle(); cycle();

    // Write then read back 0x20.
    m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'hF; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    cycle(); idle();
    m0_req = 1'b1; m0_addr = 32'h20;
    cycle(); idle(); cycle();

    // Reset in a grant cycle, reset right after a grant, then a fresh master-1 request.
    m0_req = 1'b1; m0_addr = 32'h10; rst = 1'b1;
    cycle(); rst = 1'b0; cycle(); rst = 1'b1; cycle();
    rst = 1'b0; idle(); m1_req = 1'b1; m1_addr = 32'h28;
    cycle(); idle(); cycle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      m0_req   = ($urandom_range(0, 9) < 6);
      m0_we    = ($urandom_range(0, 9) < 3);
      m0_be    = 4'($urandom);
      m0_addr  = {26'd0, 4'($urandom), 2'b00};
      m0_wdata = $urandom;
      m1_req   = ($urandom_range(0, 1) == 1);
      m1_lock  = ($urandom_range(0, 1) == 1);
      m1_we    = ($urandom_range(0, 9) < 3);
      m1_be    = 4'($urandom);
      m1_addr  = {26'd0, 4'($urandom), 2'b00};
      m1_wdata = $urandom;
      cycle();
    end
    rst = 1'b0; idle();
    cycle(); cycle();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
